div_acc: RTL

Iterative divide accelerator that sits directly downstream of the core controller. It consumes the controller's detected-division-loop pulse `StartDiv102` and its `Divident` and `Divisor` operands, and stalls fetch while it computes. It then injects instruction pairs back into the controller's 101 stage, leaving the machine state exactly as the software subtract loop would: M[1] = iteration count, M[2] = D = final remainder. Finally it redirects the PC past the loop.

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/div_core.sv | 68 ++++++
 rtl/div_acc.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the divide accelerator (div_acc).
// Build option: DIV_ACC_RADIX4_EN selects a 2-bit-per-cycle divider (8 iterations).
package cpu_pkg;

    localparam int unsigned INST_W    = 16;
    localparam int unsigned PC_W      = 16;
    localparam int unsigned ACC_DIV_W = 16;

`ifdef DIV_ACC_RADIX4_EN
    localparam int unsigned DIV_BITS_PER_ITER = 2;
`else
    localparam int unsigned DIV_BITS_PER_ITER = 1;
`endif
    localparam int unsigned DIV_ITERS = ACC_DIV_W / DIV_BITS_PER_ITER;

    localparam logic [INST_W-1:0] INST_D_EQ_A     = 16'hEC10;
    localparam logic [INST_W-1:0] INST_M_EQ_D     = 16'hE308;
    localparam logic [INST_W-1:0] INST_D_EQ_NEG_D = 16'hE3D0;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        FIX,
        INJ,
        EXIT
    } t_div_acc_state;

    // Injected instruction pair; element [0] executes first.
    typedef logic [1:0][INST_W-1:0] t_inst_pair;

    function automatic t_inst_pair mkPair(input logic [INST_W-1:0] first,
                                          input logic [INST_W-1:0] second);
        t_inst_pair p;
        p[0] = first;
        p[1] = second;
        return p;
    endfunction

endpackage

// File: rtl/div_core.sv
// div_core: unsigned restoring divider, DIV_BITS_PER_ITER quotient bits per cycle.
// Build option: DIV_ACC_RADIX4_EN (via cpu_pkg) doubles the bits retired per cycle.
module div_core
    import cpu_pkg::*;
#(
    parameter int unsigned DIV_W = ACC_DIV_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quot,
    output logic [DIV_W-1:0] rem
);

    localparam int unsigned ITERS = DIV_W / DIV_BITS_PER_ITER;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    logic [DIV_W-1:0] divReg;
    logic [DIV_W-1:0] remNext;
    logic [DIV_W-1:0] quoNext;
    logic [CNT_W-1:0] iterCnt;

    // One or two restoring steps: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        logic [DIV_W:0] partial;
        remNext = rem;
        quoNext = quot;
        partial = '0;
        for (int i = 0; i < int'(DIV_BITS_PER_ITER); i++) begin
            partial = {remNext, quoNext[DIV_W-1]};
            if (partial >= {1'b0, divReg}) begin
                partial = partial - {1'b0, divReg};
                quoNext = {quoNext[DIV_W-2:0], 1'b1};
            end else begin
                quoNext = {quoNext[DIV_W-2:0], 1'b0};
            end
            remNext = partial[DIV_W-1:0];
        end
    end

    // Load on start, iterate until the counter drains; done pulses once results are final.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            divReg  <= '0;
            quot    <= '0;
            rem     <= '0;
            iterCnt <= '0;
            done    <= 1'b0;
        end else if (start) begin
            divReg  <= divisor;
            quot    <= dividend;
            rem     <= '0;
            iterCnt <= CNT_W'(ITERS);
            done    <= 1'b0;
        end else if (iterCnt != '0) begin
            quot    <= quoNext;
            rem     <= remNext;
            iterCnt <= iterCnt - CNT_W'(1);
            done    <= (iterCnt == CNT_W'(1));
        end else begin
            done    <= 1'b0;
        end
    end

endmodule

// File: rtl/div_acc.sv
// div_acc: divide-loop accelerator; computes k/R, injects the equivalent
// instruction pairs into stage 101 and redirects the PC past the loop.
// Build option: DIV_ACC_RADIX4_EN shortens the DIV phase from 16 to 8 cycles.
module div_acc
    import cpu_pkg::*;
#(
    parameter int unsigned EXIT_OFFSET = 1,
    parameter int unsigned DIV_W       = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   StartDiv102,
    input  logic [DIV_W-1:0]       Divident,
    input  logic [DIV_W-1:0]       Divisor,
    input  logic [PC_W-1:0]        StartPc102,
    output logic                   AccBusy,
    output logic                   AccStall,
    output logic                   SelAccInst101,
    output logic [1:0][INST_W-1:0] InstFromAcc101,
    output logic                   AccPcLoad,
    output logic [PC_W-1:0]        AccPcTarget,
    output logic                   AccAbort
);

    t_div_acc_state   state;
    logic [DIV_W-1:0] nReg;
    logic [DIV_W-1:0] dReg;
    logic [DIV_W-1:0] kReg;
    logic [DIV_W-1:0] absR;
    logic [PC_W-1:0]  pcReg;
    logic             rNeg;
    logic [2:0]       injIdx;
    logic [2:0]       injNext;

    logic             divStart;
    logic             divDone;
    logic [DIV_W-1:0] divQuot;
    logic [DIV_W-1:0] divRem;

    logic             remNz;
    logic [DIV_W-1:0] kFix;
    logic [DIV_W-1:0] absFix;

    // Loop is only accelerated for strictly positive operands.
    function automatic logic badOps(input logic [DIV_W-1:0] n, input logic [DIV_W-1:0] d);
        return n[DIV_W-1] || (n == '0) || d[DIV_W-1] || (d == '0);
    endfunction

    // Pair contents by slot index; slot 3 (D=-D) only appears for a negative remainder.
    function automatic t_inst_pair pairAt(input logic [2:0]       idx,
                                          input logic [DIV_W-1:0] k,
                                          input logic [DIV_W-1:0] absVal);
        case (idx)
            3'd0:    return mkPair(INST_W'(k), INST_D_EQ_A);
            3'd1:    return mkPair(INST_W'(1), INST_M_EQ_D);
            3'd2:    return mkPair(INST_W'(absVal), INST_D_EQ_A);
            3'd3:    return mkPair(INST_D_EQ_NEG_D, INST_W'(0));
            default: return mkPair(INST_W'(2), INST_M_EQ_D);
        endcase
    endfunction

    // The divider loads in the same cycle the start is accepted, overlapping CHECK.
    assign divStart = (state == IDLE) && StartDiv102;

    div_core #(
        .DIV_W    (DIV_W)
    ) uDivCore (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (divStart),
        .dividend (Divident),
        .divisor  (Divisor),
        .done     (divDone),
        .quot     (divQuot),
        .rem      (divRem)
    );

    // Ceil correction: a nonzero remainder means one extra subtraction, leaving R = r - d.
    assign remNz   = (divRem != '0);
    assign kFix    = remNz ? divQuot + DIV_W'(1) : divQuot;
    assign absFix  = remNz ? dReg - divRem : '0;
    assign injNext = ((injIdx == 3'd2) && !rNeg) ? 3'd4 : injIdx + 3'd1;

    // Control FSM; outputs are registered alongside the state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= IDLE;
            nReg           <= '0;
            dReg           <= '0;
            kReg           <= '0;
            absR           <= '0;
            pcReg          <= '0;
            rNeg           <= 1'b0;
            injIdx         <= '0;
            AccBusy        <= 1'b0;
            AccStall       <= 1'b0;
            SelAccInst101  <= 1'b0;
            InstFromAcc101 <= '0;
            AccPcLoad      <= 1'b0;
            AccPcTarget    <= '0;
            AccAbort       <= 1'b0;
        end else begin
            AccAbort  <= 1'b0;
            AccPcLoad <= 1'b0;
            case (state)
                IDLE: begin
                    if (StartDiv102) begin
                        nReg     <= Divident;
                        dReg     <= Divisor;
                        pcReg    <= StartPc102;
                        AccBusy  <= 1'b1;
                        AccStall <= 1'b1;
                        AccAbort <= badOps(Divident, Divisor);
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (badOps(nReg, dReg)) begin
                        AccBusy  <= 1'b0;
                        AccStall <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        state    <= DIV;
                    end
                end
                DIV: begin
                    if (divDone) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    kReg           <= kFix;
                    absR           <= absFix;
                    rNeg           <= remNz;
                    injIdx         <= '0;
                    SelAccInst101  <= 1'b1;
                    InstFromAcc101 <= pairAt(3'd0, kFix, absFix);
                    state          <= INJ;
                end
                INJ: begin
                    if (injIdx == 3'd4) begin
                        SelAccInst101  <= 1'b0;
                        InstFromAcc101 <= '0;
                        AccPcLoad      <= 1'b1;
                        AccPcTarget    <= pcReg + PC_W'(EXIT_OFFSET);
                        state          <= EXIT;
                    end else begin
                        injIdx         <= injNext;
                        InstFromAcc101 <= pairAt(injNext, kReg, absR);
                    end
                end
                EXIT: begin
                    AccBusy     <= 1'b0;
                    AccStall    <= 1'b0;
                    AccPcTarget <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
